keypad_emulator: RTL

KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

---
 rtl/keypad_emulator_if.sv | 29 ++
 rtl/keypad_emulator.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_emulator_if.sv
// -----------------------------------------------------------------------------
// keypad_emulator_if
// Press-request handshake between a key-press driver and keypad_emulator.
//   press_req   : request to press one key (driver -> emulator)
//   press_key   : hex code of the key to press, sampled with press_req
//   press_ready : emulator is idle and will accept a request this cycle
//   press_done  : one-cycle pulse when a press/release sequence completes
// Modports: master = request driver, slave = emulator.
// -----------------------------------------------------------------------------
interface keypad_emulator_if;
   logic       press_req;
   logic [3:0] press_key;
   logic       press_ready;
   logic       press_done;

   modport master (
      output press_req,
      output press_key,
      input  press_ready,
      input  press_done
   );

   modport slave (
      input  press_req,
      input  press_key,
      output press_ready,
      output press_done
   );
endinterface

// File: rtl/keypad_emulator.sv
// -----------------------------------------------------------------------------
// keypad_emulator
// Emulates one mechanical key of a 4x4 matrix keypad, including contact bounce,
// so a row/column scanner and its debouncer can be exercised in isolation.
//
// Ports:
//   CLOCK_50 : sole clock, all state changes on its rising edge
//   Reset    : synchronous active-low reset
//   press    : press handshake (slave side of keypad_emulator_if)
//   cols     : column drive from the scanner, active-low (column c -> cols[3-c])
//   rows     : registered row sense to the scanner, active-low (row r -> rows[3-r])
//   contact  : current emulated switch state, 1 = closed
//
// Sequence per accepted press: BOUNCE_IN (BounceCycles) -> HOLD (HoldCycles)
// -> BOUNCE_OUT (BounceCycles) -> IDLE. With BounceCycles = 0 both bounce
// phases are skipped.
// -----------------------------------------------------------------------------
module keypad_emulator #(
   parameter int HoldCycles   = 20000,
   parameter int BounceCycles = 2000,
   parameter int BouncePeriod = 250
) (
   input  logic                CLOCK_50,
   input  logic                Reset,
   keypad_emulator_if.slave    press,
   input  logic [3:0]          cols,
   output logic [3:0]          rows,
   output logic                contact
);

   // One shared down-counter times every state, so it must hold the
   // largest load value (longest duration minus one).
   localparam int MaxCount   = (HoldCycles > BounceCycles) ? HoldCycles : BounceCycles;
   localparam int CW         = (MaxCount > 1) ? $clog2(MaxCount) : 1;
   localparam int PerClamped = (BouncePeriod < 1) ? 1 : BouncePeriod;
   localparam int PW         = (PerClamped > 1) ? $clog2(PerClamped) : 1;

   localparam logic [CW-1:0] HOLD_LOAD   = CW'((HoldCycles   > 0) ? HoldCycles   - 1 : 0);
   localparam logic [CW-1:0] BOUNCE_LOAD = CW'((BounceCycles > 0) ? BounceCycles - 1 : 0);
   localparam logic [PW-1:0] PER_LOAD    = PW'(PerClamped - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BOUNCE_IN,
      S_HOLD,
      S_BOUNCE_OUT
   } state_t;

   state_t        r_state;
   logic [CW-1:0] r_count;
   logic [PW-1:0] r_phase;
   logic          r_contact;
   logic          r_done;
   logic [3:0]    r_key;
   logic [3:0]    r_rows;

   state_t        w_state_next;
   logic [CW-1:0] w_count_next;
   logic [PW-1:0] w_phase_next;
   logic          w_contact_next;
   logic          w_done_next;
   logic [3:0]    w_key_next;
   logic [3:0]    w_rows_next;

   logic [1:0]    w_key_row;
   logic [1:0]    w_key_col;
   logic          w_col_driven;
   logic          w_count_zero;

   assign w_count_zero = (r_count == '0);

   // -------------------------------------------------------------------------
   // Next-state / next-output logic
   // -------------------------------------------------------------------------
   always_comb begin
      w_state_next   = r_state;
      w_count_next   = r_count;
      w_phase_next   = r_phase;
      w_contact_next = r_contact;
      w_done_next    = 1'b0;
      w_key_next     = r_key;

      case (r_state)
         S_IDLE: begin
            w_contact_next = 1'b0;
            if (press.press_req) begin
               w_key_next     = press.press_key;
               w_contact_next = 1'b1;
               if (BounceCycles == 0) begin
                  w_state_next = S_HOLD;
                  w_count_next = HOLD_LOAD;
               end else begin
                  w_state_next = S_BOUNCE_IN;
                  w_count_next = BOUNCE_LOAD;
                  w_phase_next = PER_LOAD;
               end
            end
         end

         S_BOUNCE_IN: begin
            if (w_count_zero) begin
               w_state_next   = S_HOLD;
               w_count_next   = HOLD_LOAD;
               w_contact_next = 1'b1;
            end else begin
               w_count_next = r_count - CW'(1);
               // Contact flips once per BouncePeriod cycles; phase counts down
               // to zero, flips, and reloads.
               if (r_phase == '0) begin
                  w_contact_next = ~r_contact;
                  w_phase_next   = PER_LOAD;
               end else begin
                  w_phase_next = r_phase - PW'(1);
               end
            end
         end

         S_HOLD: begin
            if (w_count_zero) begin
               w_contact_next = 1'b0;
               if (BounceCycles == 0) begin
                  w_state_next = S_IDLE;
                  w_done_next  = 1'b1;
               end else begin
                  w_state_next = S_BOUNCE_OUT;
                  w_count_next = BOUNCE_LOAD;
                  w_phase_next = PER_LOAD;
               end
            end else begin
               w_count_next = r_count - CW'(1);
            end
         end

         S_BOUNCE_OUT: begin
            if (w_count_zero) begin
               w_state_next   = S_IDLE;
               w_contact_next = 1'b0;
               w_done_next    = 1'b1;
            end else begin
               w_count_next = r_count - CW'(1);
               if (r_phase == '0) begin
                  w_contact_next = ~r_contact;
                  w_phase_next   = PER_LOAD;
               end else begin
                  w_phase_next = r_phase - PW'(1);
               end
            end
         end

         default: begin
            w_state_next   = S_IDLE;
            w_count_next   = '0;
            w_contact_next = 1'b0;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Key code -> matrix position
   // -------------------------------------------------------------------------
   always_comb begin
      w_key_row = 2'd0;
      w_key_col = 2'd0;
      case (r_key)
         4'h1: begin w_key_row = 2'd0; w_key_col = 2'd0; end
         4'h2: begin w_key_row = 2'd0; w_key_col = 2'd1; end
         4'h3: begin w_key_row = 2'd0; w_key_col = 2'd2; end
         4'hA: begin w_key_row = 2'd0; w_key_col = 2'd3; end
         4'h4: begin w_key_row = 2'd1; w_key_col = 2'd0; end
         4'h5: begin w_key_row = 2'd1; w_key_col = 2'd1; end
         4'h6: begin w_key_row = 2'd1; w_key_col = 2'd2; end
         4'hB: begin w_key_row = 2'd1; w_key_col = 2'd3; end
         4'h7: begin w_key_row = 2'd2; w_key_col = 2'd0; end
         4'h8: begin w_key_row = 2'd2; w_key_col = 2'd1; end
         4'h9: begin w_key_row = 2'd2; w_key_col = 2'd2; end
         4'hC: begin w_key_row = 2'd2; w_key_col = 2'd3; end
         4'hE: begin w_key_row = 2'd3; w_key_col = 2'd0; end
         4'h0: begin w_key_row = 2'd3; w_key_col = 2'd1; end
         4'hF: begin w_key_row = 2'd3; w_key_col = 2'd2; end
         4'hD: begin w_key_row = 2'd3; w_key_col = 2'd3; end
         default: begin w_key_row = 2'd0; w_key_col = 2'd0; end
      endcase
   end

   // The key's column counts as driven whenever its active-low bit is 0,
   // regardless of what the other columns are doing.
   assign w_col_driven = ~cols[2'd3 - w_key_col];

   // Only the latched key's row can be pulled low; every other row idles high.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_row
         assign w_rows_next[3-gi] = ~(r_contact & w_col_driven & (w_key_row == 2'(gi)));
      end
   endgenerate

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge CLOCK_50) begin
      if (!Reset) begin
         r_state   <= S_IDLE;
         r_count   <= '0;
         r_phase   <= '0;
         r_contact <= 1'b0;
         r_done    <= 1'b0;
         r_key     <= 4'h0;
         r_rows    <= 4'b1111;
      end else begin
         r_state   <= w_state_next;
         r_count   <= w_count_next;
         r_phase   <= w_phase_next;
         r_contact <= w_contact_next;
         r_done    <= w_done_next;
         r_key     <= w_key_next;
         r_rows    <= w_rows_next;
      end
   end

   assign press.press_ready = (r_state == S_IDLE);
   assign press.press_done  = r_done;
   assign contact           = r_contact;
   assign rows              = r_rows;

endmodule
